decoder_round_controller: RTL and testbench

//  Drives one decoding round of the single-type stabilizer grid and collects its result.

---
 rtl/decoder_round_controller.sv | 168 ++++++++++++++++
 tb/tb_decoder_round_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_round_controller.sv
// Sequences one decoding round: load a syndrome frame into the grid, offer for a fixed budget,
// then stream one (y, x, match) record per defect in row-major order over valid/ready.
module decoder_round_controller #(
    parameter int unsigned GRID_ROWS         = 4,
    parameter int unsigned GRID_COLS         = 5,
    parameter int unsigned CORDINATE_WIDTH   = 3,
    parameter int unsigned MATCH_VALUE_WIDTH = 6,
    parameter int unsigned SETTLE_CYCLES     = 100,
    parameter int unsigned OFFER_CYCLES      = 2500,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [GRID_ROWS*GRID_COLS-1:0]                   syndrome_in,
    input  logic                                             syndrome_valid,
    output logic                                             syndrome_ready,
    output logic [GRID_ROWS*GRID_COLS-1:0]                   measurement_value_out,
    output logic                                             measurement_valid_out,
    output logic                                             start_offer,
    output logic                                             stop_offer,
    input  logic [GRID_ROWS*GRID_COLS-1:0]                   measurement_in,
    input  logic [GRID_ROWS*GRID_COLS*MATCH_VALUE_WIDTH-1:0] match_value_in,
    output logic                                             result_valid,
    input  logic                                             result_ready,
    output logic [CORDINATE_WIDTH-1:0]                       result_y,
    output logic [CORDINATE_WIDTH-1:0]                       result_x,
    output logic [MATCH_VALUE_WIDTH-1:0]                     result_match,
    output logic                                             round_done,
    output logic [$clog2(GRID_ROWS*GRID_COLS+1)-1:0]         defect_count
);

    localparam int unsigned N     = GRID_ROWS * GRID_COLS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSettle,
        StStart,
        StRun,
        StStop,
        StCapture,
        StScan,
        StDone
    } state_e;

    state_e                             state;
    logic [CNT_WIDTH-1:0]               cycle_cnt;
    logic [N-1:0]                       snap_meas;
    logic [N*MATCH_VALUE_WIDTH-1:0]     snap_match;
    logic [IDX_W-1:0]                   scan_idx;
    logic [IDX_W-1:0]                   next_idx;
    logic                               scan_advance;

    assign next_idx = scan_idx + 1'b1;
    // A candidate moves on when nothing is presented (non-defect) or the record was taken.
    assign scan_advance = !result_valid || result_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= StIdle;
            cycle_cnt             <= '0;
            snap_meas             <= '0;
            snap_match            <= '0;
            scan_idx              <= '0;
            syndrome_ready        <= 1'b1;
            measurement_value_out <= '0;
            measurement_valid_out <= 1'b0;
            start_offer           <= 1'b0;
            stop_offer            <= 1'b0;
            result_valid          <= 1'b0;
            result_y              <= '0;
            result_x              <= '0;
            result_match          <= '0;
            round_done            <= 1'b0;
            defect_count          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (syndrome_valid) begin
                        measurement_value_out <= syndrome_in;
                        measurement_valid_out <= 1'b1;
                        syndrome_ready        <= 1'b0;
                        state                 <= StLoad;
                    end
                end
                StLoad: begin
                    measurement_valid_out <= 1'b0;
                    cycle_cnt             <= '0;
                    state                 <= StSettle;
                end
                StSettle: begin
                    if (cycle_cnt == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
                        start_offer <= 1'b1;
                        state       <= StStart;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                StStart: begin
                    start_offer <= 1'b0;
                    cycle_cnt   <= '0;
                    state       <= StRun;
                end
                StRun: begin
                    if (cycle_cnt == CNT_WIDTH'(OFFER_CYCLES - 1)) begin
                        stop_offer <= 1'b1;
                        state      <= StStop;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                StStop: begin
                    stop_offer <= 1'b0;
                    state      <= StCapture;
                end
                StCapture: begin
                    // Candidate 0 is preloaded straight from the grid so records stay registered.
                    snap_meas    <= measurement_in;
                    snap_match   <= match_value_in;
                    scan_idx     <= '0;
                    result_y     <= '0;
                    result_x     <= '0;
                    result_valid <= measurement_in[0];
                    result_match <= match_value_in[MATCH_VALUE_WIDTH-1:0];
                    defect_count <= '0;
                    state        <= StScan;
                end
                StScan: begin
                    if (scan_advance) begin
                        if (result_valid) begin
                            defect_count <= defect_count + 1'b1;
                        end
                        if (scan_idx == IDX_W'(N - 1)) begin
                            result_valid <= 1'b0;
                            round_done   <= 1'b1;
                            state        <= StDone;
                        end else begin
                            scan_idx     <= next_idx;
                            result_valid <= snap_meas[next_idx];
                            result_match <= snap_match[32'(next_idx) * MATCH_VALUE_WIDTH +:
                                                       MATCH_VALUE_WIDTH];
                            if (result_x == CORDINATE_WIDTH'(GRID_COLS - 1)) begin
                                result_x <= '0;
                                result_y <= result_y + 1'b1;
                            end else begin
                                result_x <= result_x + 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    round_done     <= 1'b0;
                    result_y       <= '0;
                    result_x       <= '0;
                    result_match   <= '0;
                    syndrome_ready <= 1'b1;
                    state          <= StIdle;
                end
                default: begin
                    state          <= StIdle;
                    syndrome_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_round_controller.sv
// Directed bench for decoder_round_controller: round timing, record streaming, backpressure,
// held syndrome_valid, zero-defect round and reset during RUN.
module tb_decoder_round_controller;

    localparam int N  = 20;
    localparam int MW = 6;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      syndrome_in;
    logic              syndrome_valid;
    logic              syndrome_ready;
    logic [N-1:0]      measurement_value_out;
    logic              measurement_valid_out;
    logic              start_offer;
    logic              stop_offer;
    logic [N-1:0]      measurement_in;
    logic [N*MW-1:0]   match_value_in;
    logic              result_valid;
    logic              result_ready;
    logic [CW-1:0]     result_y;
    logic [CW-1:0]     result_x;
    logic [MW-1:0]     result_match;
    logic              round_done;
    logic [4:0]        defect_count;

    always #5 clk = ~clk;

    decoder_round_controller dut (
        .clk                   (clk),
        .reset                 (reset),
        .syndrome_in           (syndrome_in),
        .syndrome_valid        (syndrome_valid),
        .syndrome_ready        (syndrome_ready),
        .measurement_value_out (measurement_value_out),
        .measurement_valid_out (measurement_valid_out),
        .start_offer           (start_offer),
        .stop_offer            (stop_offer),
        .measurement_in        (measurement_in),
        .match_value_in        (match_value_in),
        .result_valid          (result_valid),
        .result_ready          (result_ready),
        .result_y              (result_y),
        .result_x              (result_x),
        .result_match          (result_match),
        .round_done            (round_done),
        .defect_count          (defect_count)
    );

    typedef struct {
        int          idx;
        logic [2:0]  y;
        logic [2:0]  x;
        logic [5:0]  m;
    } vec_t;

    vec_t            main_tab[5];
    vec_t            one_tab[1];
    vec_t            exp_q[$];
    logic [N*MW-1:0] match_model;
    logic [N-1:0]    main_frame;
    logic [N-1:0]    one_frame;
    int              tests = 0;
    int              fails = 0;
    int              cyc   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Full round; caller leaves the DUT in IDLE. t counts cycles with t=1 being the load pulse.
    task automatic do_round(input logic [N-1:0] frame, input int bp_rec, input bit corrupt,
                            input bit hold, input logic [N-1:0] next_frame);
        int t0;
        int n;
        bit done;
        check("ready_in_idle", 32'(syndrome_ready), 1);
        syndrome_in    = frame;
        syndrome_valid = 1'b1;
        tick();
        t0 = cyc;
        check("load_pulse", 32'(measurement_valid_out), 1);
        check("load_value", 32'(measurement_value_out), 32'(frame));
        check("ready_busy", 32'(syndrome_ready), 0);
        if (hold) syndrome_in = next_frame;
        else syndrome_valid = 1'b0;
        measurement_in = frame;
        tick();
        check("load_width", 32'(measurement_valid_out), 0);
        while (!start_offer && cyc - t0 < 5000) tick();
        check("start_time", 32'(cyc - t0 + 1), 102);
        tick();
        check("start_width", 32'(start_offer), 0);
        while (!stop_offer && cyc - t0 < 5000) tick();
        check("stop_time", 32'(cyc - t0 + 1), 2603);
        tick();
        check("stop_width", 32'(stop_offer), 0);
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (corrupt && c == 1) begin
                measurement_in = '0;
                match_value_in = '1;
            end
            if (round_done) begin
                done = 1'b1;
            end else begin
                if (result_valid) begin
                    if (n >= exp_q.size()) begin
                        check("record_count", 32'(n + 1), 32'(exp_q.size()));
                        n++;
                    end else begin
                        check("defect_count_run", 32'(defect_count), 32'(n));
                        if (n == bp_rec) begin
                            result_ready = 1'b0;
                            for (int k = 0; k < 7; k++) begin
                                tick();
                                check("bp_hold", 32'({result_valid, result_y, result_x,
                                                      result_match}),
                                      32'({1'b1, exp_q[n].y, exp_q[n].x, exp_q[n].m}));
                            end
                            result_ready = 1'b1;
                        end
                        check("record", 32'({result_y, result_x, result_match}),
                              32'({exp_q[n].y, exp_q[n].x, exp_q[n].m}));
                        n++;
                    end
                end
                tick();
            end
        end
        check("round_done_seen", 32'(done), 1);
        check("done_time", 32'(cyc - t0 + 1),
              32'(2625 + ((bp_rec >= 0 && bp_rec < exp_q.size()) ? 7 : 0)));
        check("record_total", 32'(n), 32'(exp_q.size()));
        check("defect_count", 32'(defect_count), 32'(exp_q.size()));
        check("value_held", 32'(measurement_value_out), 32'(frame));
        tick();
        check("done_width", 32'(round_done), 0);
        check("ready_after_done", 32'(syndrome_ready), 1);
        check("valid_after_done", 32'(result_valid), 0);
        match_value_in = match_model;
    endtask

    initial begin
        bit stop_seen;
        main_tab[0] = '{idx: 0,  y: 3'd0, x: 3'd0, m: 6'o01};
        main_tab[1] = '{idx: 1,  y: 3'd0, x: 3'd1, m: 6'o00};
        main_tab[2] = '{idx: 12, y: 3'd2, x: 3'd2, m: 6'o23};
        main_tab[3] = '{idx: 13, y: 3'd2, x: 3'd3, m: 6'o22};
        main_tab[4] = '{idx: 15, y: 3'd3, x: 3'd0, m: 6'o30};
        one_tab[0]  = '{idx: 19, y: 3'd3, x: 3'd4, m: 6'o34};
        match_model = '0;
        main_frame  = '0;
        one_frame   = '0;
        foreach (main_tab[i]) begin
            match_model[main_tab[i].idx*MW +: MW] = main_tab[i].m;
            main_frame[main_tab[i].idx] = 1'b1;
        end
        match_model[one_tab[0].idx*MW +: MW] = one_tab[0].m;
        one_frame[one_tab[0].idx] = 1'b1;

        reset          = 1'b1;
        syndrome_in    = '0;
        syndrome_valid = 1'b0;
        result_ready   = 1'b1;
        measurement_in = '0;
        match_value_in = match_model;
        tick();
        tick();
        check("rst_ready", 32'(syndrome_ready), 1);
        check("rst_outs", 32'({measurement_valid_out, start_offer, stop_offer, result_valid,
                               round_done}), 0);
        check("rst_value", 32'(measurement_value_out), 0);
        check("rst_count", 32'(defect_count), 0);
        reset = 1'b0;
        tick();

        exp_q = {};
        foreach (main_tab[i]) exp_q.push_back(main_tab[i]);
        do_round(main_frame, -1, 1'b0, 1'b0, '0);

        // Backpressure on record 2, grid corrupted after capture, valid held into next round.
        do_round(main_frame, 1, 1'b1, 1'b1, '0);

        exp_q = {};
        do_round('0, -1, 1'b0, 1'b0, '0);

        syndrome_in    = one_frame;
        syndrome_valid = 1'b1;
        tick();
        syndrome_valid = 1'b0;
        measurement_in = one_frame;
        for (int c = 0; c < 500 && !start_offer; c++) tick();
        check("pre_reset_start", 32'(start_offer), 1);
        repeat (50) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 32'(syndrome_ready), 1);
        check("midrst_outs", 32'({measurement_valid_out, start_offer, stop_offer, result_valid,
                                  round_done}), 0);
        check("midrst_value", 32'(measurement_value_out), 0);
        stop_seen = 1'b0;
        repeat (3000) begin
            tick();
            if (stop_offer) stop_seen = 1'b1;
        end
        check("no_stop_after_reset", 32'(stop_seen), 0);

        exp_q = {};
        exp_q.push_back(one_tab[0]);
        do_round(one_frame, -1, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
